// File: rtl/w_seq_fsm_pkg.sv
// Shared types and encodings for the w_seq_fsm serial-input Moore FSM.
// Build option: define W_SEQ_FSM_ONEHOT_EN for a 6-bit one-hot state register;
// otherwise the state register is 3-bit binary.
package w_seq_fsm_pkg;

  // One-hot encodings (bit index = state position A..F)
  localparam logic [5:0] ONEHOT_A = 6'b000001;
  localparam logic [5:0] ONEHOT_B = 6'b000010;
  localparam logic [5:0] ONEHOT_C = 6'b000100;
  localparam logic [5:0] ONEHOT_D = 6'b001000;
  localparam logic [5:0] ONEHOT_E = 6'b010000;
  localparam logic [5:0] ONEHOT_F = 6'b100000;

  // Binary encodings
  localparam logic [2:0] BIN_A = 3'd0;
  localparam logic [2:0] BIN_B = 3'd1;
  localparam logic [2:0] BIN_C = 3'd2;
  localparam logic [2:0] BIN_D = 3'd3;
  localparam logic [2:0] BIN_E = 3'd4;
  localparam logic [2:0] BIN_F = 3'd5;

`ifdef W_SEQ_FSM_ONEHOT_EN
  localparam int unsigned STATE_W = 6;

  typedef enum logic [STATE_W-1:0] {
    ST_A = ONEHOT_A,
    ST_B = ONEHOT_B,
    ST_C = ONEHOT_C,
    ST_D = ONEHOT_D,
    ST_E = ONEHOT_E,
    ST_F = ONEHOT_F
  } state_t;
`else
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_A = BIN_A,
    ST_B = BIN_B,
    ST_C = BIN_C,
    ST_D = BIN_D,
    ST_E = BIN_E,
    ST_F = BIN_F
  } state_t;
`endif

  // True when exactly one bit of a 6-bit vector is set
  function automatic logic is_onehot6(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/w_seq_fsm_next.sv
// Next-state and Moore output decode for w_seq_fsm (purely combinational).
// Build option: W_SEQ_FSM_ONEHOT_EN selects per-bit one-hot equations.
module w_seq_fsm_next
  import w_seq_fsm_pkg::*;
(
  input  state_t state,
  input  logic   w,
  output state_t next_state_c,
  output logic   z_c
);

`ifdef W_SEQ_FSM_ONEHOT_EN
  logic [STATE_W-1:0] s;
  logic [STATE_W-1:0] nxt;
  logic               legal;

  // Per-bit next-state equations; any non-one-hot vector falls back to A
  always_comb begin
    s     = state;
    nxt   = ONEHOT_A;
    legal = is_onehot6(s);
    z_c   = 1'b0;
    if (legal) begin
      nxt[0] = (s[0] &  w) | (s[3] &  w);
      nxt[1] =  s[0] & ~w;
      nxt[2] = (s[1] & ~w) | (s[5] & ~w);
      nxt[3] = (s[1] | s[2] | s[4] | s[5]) & w;
      nxt[4] = (s[2] | s[4]) & ~w;
      nxt[5] =  s[3] & ~w;
      z_c    =  s[4] | s[5];
    end
    next_state_c = state_t'(nxt);
  end
`else
  // Transition table; unused codes 6 and 7 fall back to A with z low
  always_comb begin
    next_state_c = ST_A;
    z_c          = 1'b0;
    unique case (state)
      ST_A: next_state_c = w ? ST_A : ST_B;
      ST_B: next_state_c = w ? ST_D : ST_C;
      ST_C: next_state_c = w ? ST_D : ST_E;
      ST_D: next_state_c = w ? ST_A : ST_F;
      ST_E: begin
        next_state_c = w ? ST_D : ST_E;
        z_c          = 1'b1;
      end
      ST_F: begin
        next_state_c = w ? ST_D : ST_C;
        z_c          = 1'b1;
      end
      default: begin
        next_state_c = ST_A;
        z_c          = 1'b0;
      end
    endcase
  end
`endif

endmodule

// File: rtl/w_seq_fsm.sv
// w_seq_fsm top: state register with synchronous reset; z decoded from it.
// Build option: W_SEQ_FSM_ONEHOT_EN (one-hot vs binary state register).
module w_seq_fsm
  import w_seq_fsm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic w,
  output logic z
);

  state_t state_q;
  state_t state_d;
  logic   z_c;

  w_seq_fsm_next u_next (
    .state        (state_q),
    .w            (w),
    .next_state_c (state_d),
    .z_c          (z_c)
  );

  // State register; reset wins over w
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_A;
    else       state_q <= state_d;
  end

  assign z = z_c;

endmodule

// File: tb/tb_w_seq_fsm.sv
// Self-checking bench for w_seq_fsm: directed vector table, reset-in-F
// corner sequence, and a randomized run against a behavioural model.
module tb_w_seq_fsm;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic w = 1'b0;
  logic z;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic  rst;
    logic  w;
    logic  exp_z;
    string name;
  } vec_t;

  w_seq_fsm dut (
    .clk   (clk),
    .reset (reset),
    .w     (w),
    .z     (z)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: z=%b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Called at a falling edge: drive, check after the rising edge and again
  // at the following falling edge (z must hold for the full period).
  task automatic step(input logic r, input logic wv, input logic exp, input string name);
    reset = r;
    w     = wv;
    @(posedge clk);
    #1;
    check({name, "_hi"}, z, exp);
    @(negedge clk);
    check({name, "_lo"}, z, exp);
  endtask

  // Reference model: states 0..5 = A..F
  function automatic int model_next(input int s, input logic wv);
    case (s)
      0: return wv ? 0 : 1;
      1: return wv ? 3 : 2;
      2: return wv ? 3 : 4;
      3: return wv ? 0 : 5;
      4: return wv ? 3 : 4;
      5: return wv ? 3 : 2;
      default: return 0;
    endcase
  endfunction

  vec_t vecs[$];
  int   ms;

  initial begin
    vecs = '{
      '{1'b1, 1'b1, 1'b0, "rst_w1"},
      '{1'b0, 1'b1, 1'b0, "aa1"},
      '{1'b0, 1'b1, 1'b0, "aa2"},
      '{1'b0, 1'b1, 1'b0, "aa3"},
      '{1'b1, 1'b0, 1'b0, "rst_w0"},
      '{1'b0, 1'b0, 1'b0, "to_b"},
      '{1'b0, 1'b0, 1'b0, "to_c"},
      '{1'b0, 1'b0, 1'b1, "to_e"},
      '{1'b0, 1'b0, 1'b1, "e_hold"},
      '{1'b0, 1'b1, 1'b0, "e_to_d"},
      '{1'b0, 1'b0, 1'b1, "d_to_f"},
      '{1'b0, 1'b0, 1'b0, "f_to_c"},
      '{1'b0, 1'b1, 1'b0, "c_to_d"},
      '{1'b0, 1'b1, 1'b0, "d_to_a"},
      '{1'b0, 1'b0, 1'b0, "a_to_b"},
      '{1'b0, 1'b1, 1'b0, "b_to_d"},
      '{1'b0, 1'b0, 1'b1, "d_to_f2"},
      '{1'b0, 1'b1, 1'b0, "f_to_d"},
      '{1'b0, 1'b1, 1'b0, "d_to_a2"}
    };

    @(negedge clk);
    foreach (vecs[i]) step(vecs[i].rst, vecs[i].w, vecs[i].exp_z, vecs[i].name);

    // Reset asserted while in F with w=0 must go to A, not C
    step(1'b0, 1'b0, 1'b0, "seq_a_to_b");
    step(1'b0, 1'b1, 1'b0, "seq_b_to_d");
    step(1'b0, 1'b0, 1'b1, "seq_d_to_f");
    step(1'b1, 1'b0, 1'b0, "seq_rst_in_f");
    step(1'b0, 1'b0, 1'b0, "seq_after_rst_b");
    step(1'b0, 1'b0, 1'b0, "seq_after_rst_c");

    // Random: inputs change on both clock phases, z checked on both edges
    ms = 0;
    for (int i = 0; i < 100; i++) begin
      reset = (i == 0) ? 1'b1 : ($urandom_range(15) == 0);
      w     = 1'($urandom_range(1));
      @(posedge clk);
      ms = reset ? 0 : model_next(ms, w);
      #1;
      check("rand_hi", z, (ms >= 4) ? 1'b1 : 1'b0);
      reset = ($urandom_range(15) == 0);
      w     = 1'($urandom_range(1));
      @(negedge clk);
      check("rand_lo", z, (ms >= 4) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
